adc_min_window_ctrl: RTL and testbench

- Sequences measurement windows for CORE_NUM per-core ADC minimum detectors.
- Issues a window-start pulse that makes each core reset its running minimum, times the window, and waits for the cores' comparator pipeline to settle.
- Snapshots all core minima, then scans them sequentially for the global minimum and its core index.
- Serves results to the host register bank over a request/acknowledge read port; replaces the fixed millisecond tick as the cores' restart source.

---
 rtl/adc_min_window_ctrl_pkg.sv | 29 ++
 rtl/adc_min_scan_unit.sv | 72 +++++++
 rtl/adc_min_window_ctrl.sv | 149 ++++++++++++++
 tb/tb_adc_min_window_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_min_window_ctrl_pkg.sv
// rtl/adc_min_window_ctrl_pkg.sv - shared types and constants for the ADC minimum window controller
// Purpose: FSM state encoding, minimum initial value, clog2 helper and the
//          default comparator pipeline depth of the per-core detectors.
package adc_min_window_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ACCUM,
    ST_SETTLE,
    ST_LATCH,
    ST_SCAN,
    ST_COMMIT
  } state_e;

  // Wide all-ones constant; users slice off their data width.
  localparam logic [63:0] MAX_INIT = '1;

  // Must track the comparator depth inside the per-core minimum detectors.
  localparam int PIPE_LAT_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/adc_min_scan_unit.sv
// rtl/adc_min_scan_unit.sv - sequential minimum/index scanner over latched core snapshots
// Purpose: after start_i, walks sel_o over 0..N-1 one per cycle and keeps the
//          smallest din_i seen (strict less-than, lowest index wins on ties).
// Ports:   clk, rst     - clock, synchronous active-high reset
//          start_i      - begin a scan on the next cycle
//          sel_o        - snapshot index currently presented on din_i
//          din_i        - snapshot value selected by sel_o
//          done_o       - high during the last scan cycle
//          min_o, idx_o - scan result, valid the cycle after done_o
module adc_min_scan_unit
  import adc_min_window_ctrl_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int IDXW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [W-1:0]    din_i,
  output logic [IDXW-1:0] sel_o,
  output logic            done_o,
  output logic [W-1:0]    min_o,
  output logic [IDXW-1:0] idx_o
);

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  logic            busy_q, busy_d;
  logic [IDXW-1:0] sel_q, sel_d;
  logic [W-1:0]    min_q, min_d;
  logic [IDXW-1:0] idx_q, idx_d;

  always_comb begin
    busy_d = busy_q;
    sel_d  = sel_q;
    min_d  = min_q;
    idx_d  = idx_q;
    if (start_i) begin
      busy_d = 1'b1;
      sel_d  = '0;
    end else if (busy_q) begin
      // Element 0 is taken unconditionally so a stale minimum never leaks in.
      if (sel_q == '0 || din_i < min_q) begin
        min_d = din_i;
        idx_d = sel_q;
      end
      if (sel_q == LAST) busy_d = 1'b0;
      else               sel_d  = sel_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      sel_q  <= '0;
      min_q  <= MAX_INIT[W-1:0];
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      sel_q  <= sel_d;
      min_q  <= min_d;
      idx_q  <= idx_d;
    end
  end

  assign sel_o  = sel_q;
  assign done_o = busy_q && (sel_q == LAST);
  assign min_o  = min_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/adc_min_window_ctrl.sv
// rtl/adc_min_window_ctrl.sv - measurement window sequencer and global minimum finder for per-core ADC detectors
// Purpose: restarts the core detectors, times a window, waits for their
//          pipeline, snapshots all core minima, scans for the global minimum
//          and serves results over a registered request/ack read port.
// Ports:   clk, rst                      - clock, synchronous active-high reset
//          cfg_enable/oneshot/win_len    - run control and window length
//          ovr_clr                       - clears overrun_o
//          core_min_i                    - packed per-core minima
//          win_start_o, busy_o           - core restart pulse, not-idle flag
//          result_valid_o/ready_o        - commit pulse, sticky unread flag
//          overrun_o                     - sticky unread-result overwrite flag
//          rd_req, rd_sel, rd_ack, rd_data - host read port
module adc_min_window_ctrl
  import adc_min_window_ctrl_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int CORE_NUM       = 4,
  parameter int WIN_CNT_WIDTH  = 24,
  parameter int PIPE_LAT       = PIPE_LAT_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cfg_enable,
  input  logic                                        cfg_oneshot,
  input  logic [WIN_CNT_WIDTH-1:0]                    cfg_win_len,
  input  logic                                        ovr_clr,
  input  logic [ADC_DATA_WIDTH*CORE_NUM-1:0]          core_min_i,
  output logic                                        win_start_o,
  output logic                                        busy_o,
  output logic                                        result_valid_o,
  output logic                                        result_ready_o,
  output logic                                        overrun_o,
  input  logic                                        rd_req,
  input  logic [clog2(CORE_NUM+1)-1:0]                rd_sel,
  output logic                                        rd_ack,
  output logic [ADC_DATA_WIDTH+clog2(CORE_NUM)-1:0]   rd_data
);

  localparam int W    = ADC_DATA_WIDTH;
  localparam int IDXW = clog2(CORE_NUM);
  localparam int SELW = clog2(CORE_NUM + 1);
  localparam int CW   = WIN_CNT_WIDTH;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    snap_q [CORE_NUM];
  logic [W-1:0]    gmin_q;
  logic [IDXW-1:0] gidx_q;
  logic            rdy_q, ovr_q, ack_q;
  logic [W+IDXW-1:0] rdata_q, rdata_d;

  logic            scan_done;
  logic [IDXW-1:0] scan_sel, scan_idx;
  logic [W-1:0]    scan_min;
  logic            commit, glob_read;

  adc_min_scan_unit #(.W(W), .N(CORE_NUM), .IDXW(IDXW)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .start_i (state_q == ST_LATCH),
    .din_i   (snap_q[scan_sel]),
    .sel_o   (scan_sel),
    .done_o  (scan_done),
    .min_o   (scan_min),
    .idx_o   (scan_idx)
  );

  // One shared down-counter times both the window and the settle wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:   if (cfg_enable) state_d = ST_START;
      ST_START: begin
        cnt_d   = (cfg_win_len == '0) ? '0 : cfg_win_len - CW'(1);
        state_d = cfg_enable ? ST_ACCUM : ST_IDLE;
      end
      ST_ACCUM: begin
        if (!cfg_enable) state_d = ST_IDLE;
        else if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(PIPE_LAT - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_SETTLE: begin
        if (!cfg_enable)      state_d = ST_IDLE;
        else if (cnt_q == '0) state_d = ST_LATCH;
        else                  cnt_d   = cnt_q - CW'(1);
      end
      ST_LATCH:  state_d = ST_SCAN;
      ST_SCAN:   if (scan_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = (cfg_oneshot || !cfg_enable) ? ST_IDLE : ST_START;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign commit    = (state_q == ST_COMMIT);
  assign glob_read = rd_req && (rd_sel == SELW'(CORE_NUM));

  // Read mux sees pre-update register contents by construction.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_req) begin
      if (rd_sel == SELW'(CORE_NUM))     rdata_d = {gidx_q, gmin_q};
      else if (rd_sel < SELW'(CORE_NUM)) rdata_d = {{IDXW{1'b0}}, snap_q[rd_sel[IDXW-1:0]]};
      else                               rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int k = 0; k < CORE_NUM; k++) snap_q[k] <= MAX_INIT[W-1:0];
      gmin_q  <= MAX_INIT[W-1:0];
      gidx_q  <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_LATCH)
        for (int k = 0; k < CORE_NUM; k++) snap_q[k] <= core_min_i[k*W +: W];
      if (commit) begin
        gmin_q <= scan_min;
        gidx_q <= scan_idx;
      end
      // Commit dominates a same-cycle global read.
      if (commit)         rdy_q <= 1'b1;
      else if (glob_read) rdy_q <= 1'b0;
      // Set dominates clear.
      if (commit && rdy_q) ovr_q <= 1'b1;
      else if (ovr_clr)    ovr_q <= 1'b0;
      ack_q   <= rd_req;
      rdata_q <= rdata_d;
    end
  end

  assign win_start_o    = (state_q == ST_START);
  assign busy_o         = (state_q != ST_IDLE);
  assign result_valid_o = commit;
  assign result_ready_o = rdy_q;
  assign overrun_o      = ovr_q;
  assign rd_ack         = ack_q;
  assign rd_data        = rdata_q;

endmodule

// File: tb/tb_adc_min_window_ctrl.sv
// tb/tb_adc_min_window_ctrl.sv - self-checking bench for adc_min_window_ctrl
module tb_adc_min_window_ctrl;

  localparam int W = 8;
  localparam int N = 4;
  localparam int P = 4;
  localparam int FIXED = P + N + 2;  // latency beyond the window length

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_enable = 1'b0;
  logic          cfg_oneshot = 1'b0;
  logic [23:0]   cfg_win_len = '0;
  logic          ovr_clr = 1'b0;
  logic [W*N-1:0] core_min_i = '0;
  logic          win_start_o, busy_o, result_valid_o, result_ready_o, overrun_o;
  logic          rd_req = 1'b0;
  logic [2:0]    rd_sel = '0;
  logic          rd_ack;
  logic [9:0]    rd_data;

  adc_min_window_ctrl #(
    .ADC_DATA_WIDTH(W), .CORE_NUM(N), .WIN_CNT_WIDTH(24), .PIPE_LAT(P)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot),
    .cfg_win_len(cfg_win_len), .ovr_clr(ovr_clr), .core_min_i(core_min_i),
    .win_start_o(win_start_o), .busy_o(busy_o), .result_valid_o(result_valid_o),
    .result_ready_o(result_ready_o), .overrun_o(overrun_o),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ws_q[$];
  int rv_q[$];
  logic [7:0] cm [N];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (win_start_o)    ws_q.push_back(cyc);
    if (result_valid_o) rv_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: lowest value, lowest index among equals.
  function automatic logic [9:0] ref_global();
    int bi = 0;
    for (int k = 1; k < N; k++) if (cm[k] < cm[bi]) bi = k;
    return {bi[1:0], cm[bi]};
  endfunction

  task automatic apply_cm();
    for (int k = 0; k < N; k++) core_min_i[k*W +: W] = cm[k];
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (result_valid_o) seen = 1;
    end
    check("valid_seen", 32'(seen), 1);
  endtask

  task automatic do_read(input int sel, input logic [9:0] exp, input string tag);
    rd_req = 1'b1;
    rd_sel = 3'(sel);
    @(negedge clk);
    rd_req = 1'b0;
    check({tag, "_ack"}, 32'(rd_ack), 1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  // Full readback against the model: snapshots, global result, out-of-range.
  task automatic read_all(input logic [7:0] s0, s1, s2, s3, input logic [9:0] g);
    do_read(0, {2'b0, s0}, "snap0");
    do_read(1, {2'b0, s1}, "snap1");
    do_read(2, {2'b0, s2}, "snap2");
    do_read(3, {2'b0, s3}, "snap3");
    do_read(4, g, "global");
    do_read(5 + $urandom_range(0, 2), 10'h0, "oob");
  endtask

  task automatic run_oneshot(input int len);
    cfg_win_len = 24'(len);
    cfg_oneshot = 1'b1;
    cfg_enable  = 1'b1;
    wait_valid(len + 40);
    cfg_enable  = 1'b0;
  endtask

  initial begin
    logic [9:0] old_g;
    bit seen;
    int ws_n, rv_n, len;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_win_start", 32'(win_start_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_valid", 32'(result_valid_o), 0);
    check("rst_ready", 32'(result_ready_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    check("rst_ack", 32'(rd_ack), 0);
    check("rst_rdata", 32'(rd_data), 0);
    read_all(8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h0FF);

    // Abort in ACCUM cycle 3.
    for (int k = 0; k < N; k++) cm[k] = 8'($urandom_range(0, 200));
    apply_cm();
    cfg_win_len = 24'd10; cfg_oneshot = 1'b0; cfg_enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (win_start_o) seen = 1;
    end
    check("abort_start_seen", 32'(seen), 1);
    repeat (3) @(negedge clk);
    cfg_enable = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(busy_o), 0);
    ws_n = ws_q.size(); rv_n = rv_q.size();
    repeat (40) @(negedge clk);
    check("abort_no_start", 32'(ws_q.size()), 32'(ws_n));
    check("abort_no_valid", 32'(rv_q.size()), 32'(rv_n));
    read_all(8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h0FF);

    // Zero window length, one-shot.
    ws_q.delete(); rv_q.delete();
    for (int k = 0; k < N; k++) cm[k] = 8'($urandom);
    apply_cm();
    run_oneshot(0);
    @(negedge clk);
    check("len0_busy_after", 32'(busy_o), 0);
    repeat (25) @(negedge clk);
    check("len0_one_start", 32'(ws_q.size()), 1);
    check("len0_latency", 32'(rv_q[0] - ws_q[0]), 32'(1 + FIXED));
    read_all(cm[0], cm[1], cm[2], cm[3], ref_global());

    // Continuous windows: fixed length then a random length, no reads (overrun).
    for (int pass = 0; pass < 2; pass++) begin
      len = (pass == 0) ? 10 : $urandom_range(1, 15);
      ws_q.delete(); rv_q.delete();
      cfg_win_len = 24'(len); cfg_oneshot = 1'b0; cfg_enable = 1'b1;
      for (int w = 0; w < 3; w++) wait_valid(len + 40);
      cfg_enable = 1'b0;
      repeat (3) @(negedge clk);
      check("cont_starts", 32'(ws_q.size()), 3);
      for (int i = 0; i + 1 < ws_q.size(); i++)
        check("cont_period", 32'(ws_q[i+1] - ws_q[i]), 32'(len + FIXED + 1));
      for (int i = 0; i < rv_q.size() && i < ws_q.size(); i++)
        check("cont_latency", 32'(rv_q[i] - ws_q[i]), 32'(len + FIXED));
      check("cont_overrun", 32'(overrun_o), 1);
      check("cont_ready", 32'(result_ready_o), 1);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      check("ovr_cleared", 32'(overrun_o), 0);
      check("ready_kept", 32'(result_ready_o), 1);
      do_read(4, ref_global(), "cont_global");
      check("ready_cleared", 32'(result_ready_o), 0);
    end

    // Tie case then randomized windows.
    for (int t = 0; t < 7; t++) begin
      if (t == 0) begin
        cm[0] = 8'h40; cm[1] = 8'h12; cm[2] = 8'h12; cm[3] = 8'h80;
      end else if (t[0]) begin
        for (int k = 0; k < N; k++) cm[k] = 8'($urandom_range(16, 19));
      end else begin
        for (int k = 0; k < N; k++) cm[k] = 8'($urandom);
      end
      apply_cm();
      len = $urandom_range(0, 12);
      ws_q.delete(); rv_q.delete();
      run_oneshot(len);
      repeat (2) @(negedge clk);
      check("rand_latency", 32'(rv_q[0] - ws_q[0]), 32'((len == 0 ? 1 : len) + FIXED));
      check("rand_ready", 32'(result_ready_o), 1);
      if (t == 0) check("tie_global", 32'(ref_global()), 32'h112);
      read_all(cm[0], cm[1], cm[2], cm[3], ref_global());
      check("rand_no_overrun", 32'(overrun_o), 0);
      check("rand_ready_clr", 32'(result_ready_o), 0);
    end

    // Global read in the COMMIT cycle.
    for (int k = 0; k < N; k++) cm[k] = 8'($urandom);
    apply_cm();
    run_oneshot(5);
    old_g = ref_global();
    for (int k = 0; k < N; k++) cm[k] = 8'($urandom);
    apply_cm();
    cfg_win_len = 24'd7; cfg_oneshot = 1'b1; cfg_enable = 1'b1;
    wait_valid(60);
    cfg_enable = 1'b0;
    rd_req = 1'b1; rd_sel = 3'd4;
    @(negedge clk);
    rd_req = 1'b0;
    check("coll_ack", 32'(rd_ack), 1);
    check("coll_old_data", 32'(rd_data), 32'(old_g));
    check("coll_ready", 32'(result_ready_o), 1);
    check("coll_overrun", 32'(overrun_o), 1);
    do_read(4, ref_global(), "coll_new");
    check("coll_ready_clr", 32'(result_ready_o), 0);

    // Reset mid-window.
    cfg_win_len = 24'd10; cfg_oneshot = 1'b0; cfg_enable = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1; cfg_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(busy_o), 0);
    check("mrst_overrun", 32'(overrun_o), 0);
    check("mrst_ready", 32'(result_ready_o), 0);
    read_all(8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h0FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
